gpio_arbiter: RTL

GPIO_ARBITER -- requirements
Module: gpio_arbiter

---
 rtl/gpio_arbiter_if.sv | 36 +++
 rtl/gpio_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/gpio_arbiter_if.sv
// Shared-GPIO arbitration bus: two requesters, pad-side pin signals.
// The arbiter uses the slave modport; the requester/pad side uses master.
interface gpio_arbiter_if #(
    parameter int GPIO_WIDTH = 3
);
    logic                  req0_request;
    logic                  req1_request;
    logic                  req0_grant;
    logic                  req1_grant;
    logic [GPIO_WIDTH-1:0] req0_oe;
    logic [GPIO_WIDTH-1:0] req1_oe;
    logic [GPIO_WIDTH-1:0] req0_output;
    logic [GPIO_WIDTH-1:0] req1_output;
    logic [GPIO_WIDTH-1:0] gpio_input;
    logic [GPIO_WIDTH-1:0] gpio_input_sync;
    logic [GPIO_WIDTH-1:0] gpio_oe;
    logic [GPIO_WIDTH-1:0] gpio_output;

    modport slave (
        input  req0_request, req1_request,
        input  req0_oe, req1_oe,
        input  req0_output, req1_output,
        input  gpio_input,
        output req0_grant, req1_grant,
        output gpio_input_sync, gpio_oe, gpio_output
    );

    modport master (
        output req0_request, req1_request,
        output req0_oe, req1_oe,
        output req0_output, req1_output,
        output gpio_input,
        input  req0_grant, req1_grant,
        input  gpio_input_sync, gpio_oe, gpio_output
    );
endinterface

// File: rtl/gpio_arbiter.sv
// Two-requester round-robin owner of a shared GPIO bank.
// Define GPIO_ARBITER_TIMEOUT_EN to preempt an owner after HOLD_TIMEOUT contended cycles.
module gpio_arbiter #(
    parameter int GPIO_WIDTH   = 3,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic          clock,
    input  logic          reset,
    gpio_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_grant0;
    logic                  r_grant1;
    logic [GPIO_WIDTH-1:0] r_oe;
    logic [GPIO_WIDTH-1:0] r_out;
    logic [GPIO_WIDTH-1:0] r_sync1;
    logic [GPIO_WIDTH-1:0] r_sync2;
    logic                  w_expire;

`ifdef GPIO_ARBITER_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);

    logic [15:0] r_hold;
    logic        w_contend;
    logic        w_leave;

    assign w_contend = ((r_state == GRANT0) && bus.req1_request) ||
                       ((r_state == GRANT1) && bus.req0_request);
    assign w_leave   = ((r_state == GRANT0) && !bus.req0_request) ||
                       ((r_state == GRANT1) && !bus.req1_request);
    assign w_expire  = w_contend && (r_hold == HOLD_LAST);

    // Count contended ownership cycles; any release or idle clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold <= 16'd0;
        end else if (w_contend && !w_expire && !w_leave) begin
            r_hold <= r_hold + 16'd1;
        end else begin
            r_hold <= 16'd0;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Ownership FSM; grants and pad drive are registered with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant0     <= 1'b0;
            r_grant1     <= 1'b0;
            r_oe         <= '0;
            r_out        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.req0_request &&
                        (!bus.req1_request || r_last_grant)) begin
                        r_state      <= GRANT0;
                        r_last_grant <= 1'b0;
                        r_grant0     <= 1'b1;
                        r_oe         <= bus.req0_oe;
                        r_out        <= bus.req0_output;
                    end else if (bus.req1_request) begin
                        r_state      <= GRANT1;
                        r_last_grant <= 1'b1;
                        r_grant1     <= 1'b1;
                        r_oe         <= bus.req1_oe;
                        r_out        <= bus.req1_output;
                    end else begin
                        r_oe  <= '0;
                        r_out <= '0;
                    end
                end
                GRANT0: begin
                    if (!bus.req0_request || w_expire) begin
                        r_state  <= IDLE;
                        r_grant0 <= 1'b0;
                        r_oe     <= '0;
                        r_out    <= '0;
                    end else begin
                        r_oe  <= bus.req0_oe;
                        r_out <= bus.req0_output;
                    end
                end
                GRANT1: begin
                    if (!bus.req1_request || w_expire) begin
                        r_state  <= IDLE;
                        r_grant1 <= 1'b0;
                        r_oe     <= '0;
                        r_out    <= '0;
                    end else begin
                        r_oe  <= bus.req1_oe;
                        r_out <= bus.req1_output;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_grant0 <= 1'b0;
                    r_grant1 <= 1'b0;
                    r_oe     <= '0;
                    r_out    <= '0;
                end
            endcase
        end
    end

    // Two-flop synchronizer for pad input levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.gpio_input;
            r_sync2 <= r_sync1;
        end
    end

    assign bus.req0_grant      = r_grant0;
    assign bus.req1_grant      = r_grant1;
    assign bus.gpio_oe         = r_oe;
    assign bus.gpio_output     = r_out;
    assign bus.gpio_input_sync = r_sync2;
endmodule
